ram_bus_ctrl: RTL and testbench

//  Memory bus controller between the CPU core and the asynchronous 32 KiB x 8 RAM.

---
 rtl/ram_bus_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_ram_bus_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: byte-wide req/ack bridge from the CPU core to an asynchronous
// 32 KiB x 8 RAM with programmable setup / strobe / hold timing.
//
// Every output is registered from the state held during the previous cycle.
// As a result the RAM pins trail the FSM by one cycle, and ack appears
// SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after the accept edge.
//
// Optional feature macro: RAM_BUS_CTRL_RDCACHE_EN. When it is defined, a
// single-entry write-through read cache is added. A read hit goes straight
// to DONE.
//
// state  | meaning
// IDLE   | waiting for req; request fields latched on accept
// SETUP  | address (and write data) stable, no strobe
// STROBE | ram_r / ram_w asserted
// HOLD   | strobe released, address/data still held
// DONE   | ack pulse, rdata update

module ram_bus_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_oe,
    output logic              ram_r,
    output logic              ram_w
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_SH > STROBE_CYC) ? MAX_SH : STROBE_CYC;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    // Down-counter load values: a phase ends when the counter reaches zero.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                ram_r_q, ram_r_d;
    logic                ram_w_q, ram_w_d;
    logic                ram_oe_q, ram_oe_d;
    logic                accept;
    logic                rd_hit;

    assign accept = (state_q == S_IDLE) && req;

`ifdef RAM_BUS_CTRL_RDCACHE_EN
    logic                cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0]   cache_tag_q, cache_tag_d;
    logic [DATA_W-1:0]   cache_data_q, cache_data_d;

    assign rd_hit = !we && cache_valid_q && (cache_tag_q == addr);

    // Cache fill on every completed read, write-through update on a tag match.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if (state_q == S_DONE) begin
            if (!we_q) begin
                cache_valid_d = 1'b1;
                cache_tag_d   = addr_q;
                cache_data_d  = rdata_d;
            end else if (cache_valid_q && (cache_tag_q == addr_q)) begin
                cache_data_d  = wdata_q;
            end
        end
    end
`else
    assign rd_hit = 1'b0;
`endif

    // State register plus every datapath and output flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cap_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            ram_r_q  <= 1'b0;
            ram_w_q  <= 1'b0;
            ram_oe_q <= 1'b0;
`ifdef RAM_BUS_CTRL_RDCACHE_EN
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            ram_r_q  <= ram_r_d;
            ram_w_q  <= ram_w_d;
            ram_oe_q <= ram_oe_d;
`ifdef RAM_BUS_CTRL_RDCACHE_EN
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
`endif
        end
    end

    // Next-state and phase timer; zero-length SETUP/HOLD are bypassed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (rd_hit) begin
                        state_d = S_DONE;
                    end else if (SETUP_CYC > 0) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = S_STROBE;
                        cnt_d   = STROBE_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    if (HOLD_CYC > 0) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state, registered on the next edge.
    always_comb begin
        ram_r_d  = (state_q == S_STROBE) && !we_q;
        ram_w_d  = (state_q == S_STROBE) && we_q;
        ram_oe_d = we_q && ((state_q == S_SETUP) || (state_q == S_STROBE) ||
                            (state_q == S_HOLD));
        ack_d    = (state_q == S_DONE);
        busy_d   = busy_q;
        if (accept) begin
            busy_d = 1'b1;
        end else if (state_q == S_DONE) begin
            busy_d = 1'b0;
        end
        rdata_d  = rdata_q;
        // With HOLD_CYC=0 the strobe is still up here, so take the bus directly.
        if ((state_q == S_DONE) && !we_q) begin
            rdata_d = ram_r_q ? ram_din : cap_q;
        end
    end

    // Request latch and read-data capture while the read strobe is up.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        if (accept) begin
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
        end
`ifdef RAM_BUS_CTRL_RDCACHE_EN
        if (accept && rd_hit) begin
            cap_d = cache_data_q;
        end else if (ram_r_q) begin
            cap_d = ram_din;
        end
`else
        if (ram_r_q) begin
            cap_d = ram_din;
        end
`endif
    end

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign ram_addr = addr_q;
    assign ram_dout = wdata_q;
    assign ram_oe   = ram_oe_q;
    assign ram_r    = ram_r_q;
    assign ram_w    = ram_w_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench for ram_bus_ctrl with the default timing (1/2/1). It includes a
// behavioural async RAM. Cycle k means the clock period after the k-th edge
// that follows the accept edge. Build with RAM_BUS_CTRL_RDCACHE_EN to get the
// cached expectations.

module tb_ram_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        busy;
    logic [14:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_oe;
    logic        ram_r;
    logic        ram_w;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    logic [7:0]  mem [0:32767];
    logic        pl_en;
    logic [14:0] pl_addr;
    logic [7:0]  pl_data;

    logic [15:0] m_r, m_w, m_oe, m_ack, m_busy;
    logic [14:0] tr_addr  [0:15];
    logic [7:0]  tr_rdata [0:15];
    logic [7:0]  tr_dout  [0:15];

    ram_bus_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din),
        .ram_oe   (ram_oe),
        .ram_r    (ram_r),
        .ram_w    (ram_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_din = mem[ram_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_w && ram_oe) begin
            mem[ram_addr] <= ram_dout;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    // Present a request; returns right after the accept edge.
    task automatic start(input logic t_we, input logic [14:0] t_addr, input logic [7:0] t_wdata);
        req   = 1'b1;
        we    = t_we;
        addr  = t_addr;
        wdata = t_wdata;
        @(posedge clk);
    endtask

    // Sample n cycles into masks. On an ack before the n_acks-th, the held
    // request switches to a read; the n_acks-th ack drops req.
    task automatic record(input int n, input int n_acks);
        int acks;
        acks   = 0;
        m_r    = '0;
        m_w    = '0;
        m_oe   = '0;
        m_ack  = '0;
        m_busy = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            m_r[k]      = ram_r;
            m_w[k]      = ram_w;
            m_oe[k]     = ram_oe;
            m_ack[k]    = ack;
            m_busy[k]   = busy;
            tr_addr[k]  = ram_addr;
            tr_rdata[k] = rdata;
            tr_dout[k]  = ram_dout;
            if (ram_r && ram_w) overlap++;
            if (ack) begin
                acks++;
                if (acks >= n_acks) req = 1'b0;
                else we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 15'h1234;
        wdata = 8'h5A;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;

        // 1: reset with req high
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_val("rst_ctrl", {ack, busy, ram_r, ram_w, ram_oe}, 5'b0);
            chk_val("rst_bus", {rdata, ram_addr, ram_dout}, 31'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        preload(15'h0001, 8'hC3);
        preload(15'h0010, 8'h3C);

        // 2: write 0x5A to 0x1234
        start(1'b1, 15'h1234, 8'h5A);
        record(8, 1);
        chk_val("wr_w_mask", 32'(m_w), 32'h000C);
        chk_val("wr_oe_mask", 32'(m_oe), 32'h001E);
        chk_val("wr_r_mask", 32'(m_r), 32'h0000);
        chk_val("wr_ack_mask", 32'(m_ack), 32'h0020);
        chk_val("wr_busy_mask", 32'(m_busy), 32'h001F);
        chk_val("wr_addr", 32'(tr_addr[2]), 32'h1234);
        chk_val("wr_dout", 32'(tr_dout[2]), 32'h5A);
        chk_val("wr_mem", 32'(mem[15'h1234]), 32'h5A);
        chk_val("wr_rdata_kept", 32'(tr_rdata[5]), 32'h00);

        // 3: read it back, then a write must not disturb rdata
        start(1'b0, 15'h1234, 8'h00);
        record(8, 1);
        chk_val("rd_r_mask", 32'(m_r), 32'h000C);
        chk_val("rd_oe_mask", 32'(m_oe), 32'h0000);
        chk_val("rd_w_mask", 32'(m_w), 32'h0000);
        chk_val("rd_ack_mask", 32'(m_ack), 32'h0020);
        chk_val("rd_rdata_pre", 32'(tr_rdata[4]), 32'h00);
        chk_val("rd_rdata", 32'(tr_rdata[5]), 32'h5A);
        start(1'b1, 15'h0002, 8'h33);
        record(8, 1);
        chk_val("rd_rdata_after_wr", 32'(tr_rdata[7]), 32'h5A);

        // 4: req held high, write 0x7FFF=0xA5 then read 0x7FFF
        overlap = 0;
        start(1'b1, 15'h7FFF, 8'hA5);
        record(14, 2);
        chk_val("b2b_w_mask", 32'(m_w), 32'h000C);
        chk_val("b2b_r_mask", 32'(m_r), 32'h0300);
        chk_val("b2b_ack_mask", 32'(m_ack), 32'h0820);
        chk_val("b2b_busy_mask", 32'(m_busy), 32'h07DF);
        chk_val("b2b_addr", 32'(tr_addr[8]), 32'h7FFF);
        chk_val("b2b_rdata", 32'(tr_rdata[11]), 32'hA5);
        chk_val("b2b_overlap", 32'(overlap), 32'h0);

        // 5: reset during the 2nd strobe cycle of a write
        start(1'b1, 15'h0040, 8'h11);
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk_val("rst5_w_c3", 32'(ram_w), 32'h1);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk_val("rst5_ctrl_c4", {ack, busy, ram_r, ram_w, ram_oe}, 5'b0);
        chk_val("rst5_rdata_c4", 32'(rdata), 32'h00);
        rst = 1'b0;
        record(6, 1);
        chk_val("rst5_no_ack", 32'(m_ack), 32'h0000);
        chk_val("rst5_no_w", 32'(m_w), 32'h0000);
        start(1'b0, 15'h0001, 8'h00);
        record(8, 1);
        chk_val("rst5_rd_ack", 32'(m_ack), 32'h0020);
        chk_val("rst5_rd_r", 32'(m_r), 32'h000C);
        chk_val("rst5_rd_rdata", 32'(tr_rdata[5]), 32'hC3);

        // 6: repeated read of 0x0010, write-through, read again
        start(1'b0, 15'h0010, 8'h00);
        record(8, 1);
        chk_val("c_rd1_ack", 32'(m_ack), 32'h0020);
        chk_val("c_rd1_rdata", 32'(tr_rdata[5]), 32'h3C);
        start(1'b0, 15'h0010, 8'h00);
        record(8, 1);
`ifdef RAM_BUS_CTRL_RDCACHE_EN
        chk_val("c_rd2_ack", 32'(m_ack), 32'h0002);
        chk_val("c_rd2_r", 32'(m_r), 32'h0000);
        chk_val("c_rd2_busy", 32'(m_busy), 32'h0001);
        chk_val("c_rd2_rdata", 32'(tr_rdata[1]), 32'h3C);
`else
        chk_val("c_rd2_ack", 32'(m_ack), 32'h0020);
        chk_val("c_rd2_r", 32'(m_r), 32'h000C);
        chk_val("c_rd2_rdata", 32'(tr_rdata[5]), 32'h3C);
`endif
        start(1'b1, 15'h0010, 8'h77);
        record(8, 1);
        chk_val("c_wr_ack", 32'(m_ack), 32'h0020);
        chk_val("c_wr_w", 32'(m_w), 32'h000C);
        start(1'b0, 15'h0010, 8'h00);
        record(8, 1);
`ifdef RAM_BUS_CTRL_RDCACHE_EN
        chk_val("c_rd3_ack", 32'(m_ack), 32'h0002);
        chk_val("c_rd3_r", 32'(m_r), 32'h0000);
        chk_val("c_rd3_rdata", 32'(tr_rdata[1]), 32'h77);
`else
        chk_val("c_rd3_ack", 32'(m_ack), 32'h0020);
        chk_val("c_rd3_rdata", 32'(tr_rdata[5]), 32'h77);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
